// File: rtl/row_writer.sv
// Packs a row of PE result elements into SRAM-width words and writes them to
// consecutive SRAM addresses, with one word of look-ahead buffering.
module row_writer #(
  parameter int SRAM_DATA_WIDTH = 64,
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_reg_clear,
  input  logic                       i_start,
  input  logic [ADDR_WIDTH-1:0]      i_base_addr,
  input  logic [1:0]                 i_p_mode,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_last,
  output logic [SRAM_DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0]      o_addr,
  output logic                       o_write_en,
  input  logic                       i_write_ready,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [ADDR_WIDTH-1:0]      o_word_count
);

  localparam int LANES_FULL = SRAM_DATA_WIDTH / DATA_WIDTH;
  localparam int LANES_MAX  = 4 * LANES_FULL;
  localparam int CNT_W      = $clog2(LANES_MAX + 1);
  localparam int EW0        = DATA_WIDTH;
  localparam int EW1        = DATA_WIDTH / 2;
  localparam int EW2        = DATA_WIDTH / 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACTIVE = 2'b01,
    S_FLUSH  = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [1:0]                 r_mode;
  logic [CNT_W-1:0]           r_cnt;
  logic [CNT_W-1:0]           w_lanes;
  logic [CNT_W-1:0]           w_cnt_cand;
  logic [SRAM_DATA_WIDTH-1:0] r_asm;
  logic [SRAM_DATA_WIDTH-1:0] w_elem;
  logic [SRAM_DATA_WIDTH-1:0] w_asm_cand;
  logic [SRAM_DATA_WIDTH-1:0] r_out_data;
  logic                       r_out_vld;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [ADDR_WIDTH-1:0]      r_word_count;
  logic [15:0]                w_shamt;
  logic                       w_clear;
  logic                       w_full;
  logic                       w_xfer;
  logic                       w_wr;
  logic                       w_out_free;
  logic                       w_seal;
  logic                       w_move;

  assign w_clear = i_rst | i_reg_clear;

  // Lane geometry for the latched precision: lane count, masked element, bit offset.
  always_comb begin
    w_lanes = CNT_W'(LANES_FULL);
    w_elem  = '0;
    w_shamt = 16'(r_cnt) * 16'(EW0);
    case (r_mode)
      2'b01: begin
        w_lanes           = CNT_W'(2 * LANES_FULL);
        w_elem[EW1-1:0]   = i_data[EW1-1:0];
        w_shamt           = 16'(r_cnt) * 16'(EW1);
      end
      2'b10: begin
        w_lanes           = CNT_W'(4 * LANES_FULL);
        w_elem[EW2-1:0]   = i_data[EW2-1:0];
        w_shamt           = 16'(r_cnt) * 16'(EW2);
      end
      default: begin
        w_elem[EW0-1:0]   = i_data;
      end
    endcase
  end

  assign w_full     = (r_cnt == w_lanes);
  assign o_ready    = (r_state == S_ACTIVE) && !w_full;
  assign w_xfer     = o_ready && i_valid;
  assign w_wr       = r_out_vld && i_write_ready;
  assign w_out_free = !r_out_vld || w_wr;

  assign w_asm_cand = w_xfer ? (r_asm | (w_elem << w_shamt)) : r_asm;
  assign w_cnt_cand = w_xfer ? (r_cnt + 1'b1) : r_cnt;

  // A word is sealed when full, or when the row has ended with lanes still pending;
  // unused lanes are already zero because the assembly register clears on every move.
  assign w_seal = (w_cnt_cand != '0) &&
                  ((w_cnt_cand == w_lanes) || (r_state == S_FLUSH) || (w_xfer && i_last));
  assign w_move = w_seal && w_out_free;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_xfer && i_last) w_state_nxt = S_FLUSH;
      S_FLUSH:  if ((r_cnt == '0) && !r_out_vld) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_state      <= S_IDLE;
      r_mode       <= 2'b00;
      r_cnt        <= '0;
      r_asm        <= '0;
      r_out_data   <= '0;
      r_out_vld    <= 1'b0;
      r_addr       <= '0;
      r_word_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && i_start) begin
        r_mode       <= (i_p_mode == 2'b11) ? 2'b00 : i_p_mode;
        r_addr       <= i_base_addr;
        r_word_count <= '0;
        r_cnt        <= '0;
        r_asm        <= '0;
      end else begin
        if (w_move) begin
          r_out_data <= w_asm_cand;
          r_asm      <= '0;
          r_cnt      <= '0;
        end else begin
          r_asm <= w_asm_cand;
          r_cnt <= w_cnt_cand;
        end
        if (w_move) begin
          r_out_vld <= 1'b1;
        end else if (w_wr) begin
          r_out_vld <= 1'b0;
        end
        // o_addr always names the word in the output register, so it advances per write.
        if (w_wr) begin
          r_addr       <= r_addr + 1'b1;
          r_word_count <= r_word_count + 1'b1;
        end
      end
    end
  end

  assign o_data       = r_out_data;
  assign o_addr       = r_addr;
  assign o_write_en   = r_out_vld;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_word_count = r_word_count;

endmodule

// File: doc/row_writer.md
ROW_WRITER -- requirements
Module: row_writer

Interface
REQ-001 Parameter SRAM_DATA_WIDTH, default 64, SHALL set the SRAM write-word width.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the width of one PE result element.
REQ-003 Parameter ADDR_WIDTH, default 8, SHALL set the SRAM word-address width.
REQ-004 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 i_rst  input  1  reset, synchronous and active-high.
REQ-006 i_reg_clear  input  1  synchronous soft clear, same effect as i_rst.
REQ-007 i_start  input  1  begin a row; sampled only in IDLE.
REQ-008 i_base_addr  input  ADDR_WIDTH  first SRAM word address, latched on i_start.
REQ-009 i_p_mode  input  2  element precision, latched on i_start: 00 = DATA_WIDTH, 01 = DATA_WIDTH/2, 10 = DATA_WIDTH/4, 11 reserved (treated as 00).
REQ-010 i_data  input  DATA_WIDTH  PE result; in sub-width modes only the low bits are packed.
REQ-011 i_valid / o_ready  input / output  1 each  element handshake; transfer when both high.
REQ-012 i_last  input  1  qualifies the transferring element as the last of the row.
REQ-013 o_data  output  SRAM_DATA_WIDTH  packed SRAM write word.
REQ-014 o_addr  output  ADDR_WIDTH  SRAM write address for o_data.
REQ-015 o_write_en / i_write_ready  output / input  1 each  SRAM write handshake; a word is written when both are high.
REQ-016 o_busy  output  1  high whenever the state is not IDLE.
REQ-017 o_done  output  1  one-cycle pulse when a row is completely written.
REQ-018 o_word_count  output  ADDR_WIDTH  number of words written since the last i_start.

Function
REQ-019 The block SHALL implement states IDLE, ACTIVE, FLUSH, and DONE.
REQ-020 IDLE with i_start=1 SHALL latch i_base_addr and i_p_mode, zero the counters, and enter ACTIVE the next cycle.
REQ-021 LANES SHALL equal SRAM_DATA_WIDTH/DATA_WIDTH times 1, 2, or 4 for p_mode 00, 01, or 10 respectively (8/16/32 at default parameters).
REQ-022 Element k of a word SHALL occupy bits [(k+1)*EW-1 : k*EW], where EW is the element width, with the first accepted element at lane 0.
REQ-023 An assembly register SHALL collect elements, and an output register SHALL hold the word presented on o_data/o_addr while o_write_en=1.
REQ-024 When the assembly register reaches LANES elements, the word SHALL move to the output register on that same edge if the output register is empty or is being written in that cycle; otherwise it SHALL remain in the assembly register.
REQ-025 o_ready SHALL be 1 only in ACTIVE, and SHALL be 0 while the assembly register holds a complete word that could not move to the output register.
REQ-026 While o_write_en=1 and i_write_ready=0, o_data and o_addr SHALL stay stable.
REQ-027 Each SRAM write SHALL increment o_addr and o_word_count by 1, wrapping modulo 2^ADDR_WIDTH with no error indication.
REQ-028 A transfer with i_last=1 SHALL mark the row ended and SHALL cause a transition to FLUSH; in FLUSH o_ready SHALL be 0.
REQ-029 A partial assembly word at row end SHALL be zero-padded in its unused lanes and emitted as a normal word.
REQ-030 A row end with an empty assembly register SHALL emit no extra word.
REQ-031 FLUSH SHALL move to DONE once both the assembly and output registers are empty.
REQ-032 DONE SHALL assert o_done for exactly one cycle and then return to IDLE.
REQ-033 Inputs i_start, i_data, i_valid, and i_last SHALL be ignored outside the states in which they are sampled.
REQ-034 i_rst or i_reg_clear asserted in mid-row SHALL discard all buffered data without issuing a write, and SHALL take effect on the next edge.

Reset
REQ-035 On reset the state SHALL be IDLE, and o_data, o_addr, o_word_count, o_write_en, o_done, o_busy, and o_ready SHALL all be 0.
REQ-036 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-037 Full word: i_base_addr=0x10, p_mode=00, 8 elements 0x01..0x08 with the 8th carrying i_last, i_write_ready=1 -> one write of o_data=0x0807060504030201 at o_addr=0x10, o_done pulses, o_word_count=1.
REQ-038 Partial word: p_mode=00, 3 elements 0xAA,0xBB,0xCC with i_last on the third -> o_data=0x0000000000CCBBAA, then o_done.
REQ-039 Backpressure: 24 elements with i_write_ready held 0 after the first word -> o_ready drops after the 16th accepted element, o_data stays stable; on release, writes go to base, base+1, base+2 in order.
REQ-040 Sub-width: p_mode=01, 16 elements 0x1..0xF,0x0 (values 0x11 driven, low nibble packed) -> single word 0x0FEDCBA987654321 shape per lane order, exactly one write.
REQ-041 Wrap: base=0xFF, 2 full words -> writes at addresses 0xFF and 0x00.
REQ-042 Mid-row reset: i_rst after 5 elements -> no write, all outputs 0 the next cycle, and a new i_start works normally.
